// File: rtl/multiword_adder_seq.sv
// Sequential multi-word adder: one shared 16-bit adder steps through WORDS words, low word first.
// Optional subtract mode is enabled by defining MULTIWORD_ADDER_SEQ_SUB_EN (adds input port sub).

module full_adder_16bit (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);
  assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {16'b0, i_cin};
endmodule

module multiword_adder_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*WORDS-1:0]  op_a,
  input  logic [16*WORDS-1:0]  op_b,
  input  logic                 cin,
`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*WORDS-1:0]  result,
  output logic                 cout,
  output logic                 overflow
);

  localparam int unsigned IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IW-1:0]       r_idx;
  logic                r_carry;
  logic                r_sub;
  logic [16*WORDS-1:0] r_a;
  logic [16*WORDS-1:0] r_b;
  logic [16*WORDS-1:0] r_result;
  logic                r_cout;
  logic                r_ovf;

  logic                w_sub_in;
  logic [31:0]         w_base;
  logic [15:0]         w_a_word;
  logic [15:0]         w_b_word;
  logic [15:0]         w_sum;
  logic                w_cout;
  logic                w_ovf;
  logic                w_last;

`ifdef MULTIWORD_ADDER_SEQ_SUB_EN
  assign w_sub_in = sub;
`else
  assign w_sub_in = 1'b0;
`endif

  assign w_base   = {{(32-IW){1'b0}}, r_idx} << 4;
  assign w_a_word = r_a[w_base +: 16];
  // Subtraction is A + ~B + 1; the +1 comes from the carry register seeded at capture.
  assign w_b_word = r_b[w_base +: 16] ^ {16{r_sub}};
  assign w_last   = (r_idx == IW'(WORDS-1));
  assign w_ovf    = (w_a_word[15] == w_b_word[15]) && (w_sum[15] != w_a_word[15]);

  full_adder_16bit u_add (
    .i_a    (w_a_word),
    .i_b    (w_b_word),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = HOLD;
      HOLD:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= op_a;
            r_b     <= op_b;
            r_sub   <= w_sub_in;
            r_idx   <= '0;
            r_carry <= w_sub_in ? 1'b1 : cin;
          end
        end
        RUN: begin
          r_result[w_base +: 16] <= w_sum;
          r_carry                <= w_cout;
          r_idx                  <= r_idx + 1'b1;
          if (w_last) begin
            r_cout <= w_cout;
            r_ovf  <= w_ovf;
            r_idx  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == HOLD);
  assign result    = r_result;
  assign cout      = r_cout;
  assign overflow  = r_ovf;

endmodule

// File: doc/multiword_adder_seq.md
MULTIWORD_ADDER_SEQ -- requirements
Module: multiword_adder_seq

Interface
REQ-001 Parameter WORDS, default 4, number of 16-bit words per operand; legal range 2..8.
REQ-002 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port in_valid  input  1  operand transfer request.
REQ-005 Port in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 Port op_a  input  16*WORDS  operand A, word 0 = bits [15:0].
REQ-007 Port op_b  input  16*WORDS  operand B, same layout.
REQ-008 Port cin  input  1  carry into word 0.
REQ-009 Port out_valid  output  1  result valid; high only in HOLD.
REQ-010 Port out_ready  input  1  consumer accepts result.
REQ-011 Port result  output  16*WORDS  registered sum.
REQ-012 Port cout  output  1  carry out of the top word.
REQ-013 Port overflow  output  1  signed overflow of the full-width operation.

Function
REQ-014 The block SHALL contain exactly one full_adder_16bit instance, shared across all word steps.
REQ-015 FSM states SHALL be IDLE, RUN, HOLD.
REQ-016 IDLE: in_valid && in_ready at an edge SHALL capture op_a, op_b, cin; clear word index to 0; go to RUN.
REQ-017 RUN: each cycle SHALL add word[idx] of A and B with the carry register, write the sum to result word idx, load the carry register from adder cout, and increment idx.
REQ-018 RUN with idx == WORDS-1 SHALL go to HOLD and latch cout and overflow from that step.
REQ-019 overflow SHALL be set when the top bits of the A and B words are equal and the top sum bit differs from them.
REQ-020 Latency: out_valid SHALL rise exactly WORDS+1 cycles after the accepting cycle; WORDS=4 gives 5 cycles.
REQ-021 HOLD: result, cout, overflow and out_valid SHALL stay stable until out_valid && out_ready; the next state is then IDLE.
REQ-022 in_valid outside IDLE SHALL be ignored; operands captured in IDLE SHALL not change during RUN.
REQ-023 Result words not yet written in RUN SHALL keep their previous values; only HOLD contents are defined.
REQ-024 Back-to-back transfers SHALL have one IDLE cycle between out handshake and the next accept.

Reset
REQ-025 When rst is sampled high, the block SHALL force state IDLE, idx 0, carry register 0, result 0, cout 0, overflow 0, out_valid 0, regardless of state, including mid-RUN.
REQ-026 in_ready SHALL be 1 in the first cycle after reset deassertion; rst SHALL take priority over in_valid and out_ready.

Configuration
REQ-027 Macro MULTIWORD_ADDER_SEQ_SUB_EN, when defined, SHALL add port sub (input, 1), captured with the operands.
REQ-028 With the macro and sub=1, each B word SHALL be inverted before the adder, and the initial carry SHALL be forced to 1 (cin ignored); the result is A-B, and cout=1 means no borrow.
REQ-029 Without the macro, the sub port SHALL be absent and the block SHALL add only.

Verification (WORDS=4)
REQ-030 A=0x0000_0000_0000_FFFF, B=0x1, cin=0 -> result 0x0000_0000_0001_0000, cout 0, overflow 0, out_valid 5 cycles after accept.
REQ-031 A=0xFFFF_FFFF_FFFF_FFFF, B=0, cin=1 -> result 0, cout 1, overflow 0.
REQ-032 A=0x7FFF_FFFF_FFFF_FFFF, B=1, cin=0 -> result 0x8000_0000_0000_0000, overflow 1, cout 0.
REQ-033 out_ready held low 3 cycles in HOLD, in_valid pulsed -> outputs stable, in_ready 0, no capture; out_ready high -> IDLE next cycle.
REQ-034 rst high after 2 RUN steps -> next cycle out_valid 0, in_ready 1, result 0; the following transaction is correct.
REQ-035 MULTIWORD_ADDER_SEQ_SUB_EN defined, sub=1, A=5, B=7 -> result 0xFFFF_FFFF_FFFF_FFFE, cout 0, overflow 0.
